dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the ARM core and a second bus master, such as a DMA or debug loader. It sits between the requesters and `dmem`, replacing the direct `arm`→`dmem` connection in `top`. Grants are registered (Moore) and drive a mux onto `dmem`'s `MemWrite`/`DataAdr`/`WriteData`. A burst counter bounds how long one owner holds the port while the other waits.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_BURST`, 4, max consecutive granted cycles while the other requester waits (≥1)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`  in  1  requester 0 (ARM core) access request, held for the whole access/burst
- `we0`  in  1  requester 0 write enable
- `adr0`  in  AW  requester 0 address
- `wd0`  in  DW  requester 0 write data
- `gnt0`  out  1  requester 0 owns port (registered)
- `rd0`  out  DW  read data to requester 0
- `req1`, `we1`, `adr1`, `wd1`, `gnt1`, `rd1`: same as above for requester 1 (DMA/debug)
- `MemWrite`  out  1  dmem write strobe
- `DataAdr`  out  AW  dmem address
- `WriteData`  out  DW  dmem write data
- `ReadData`  in  DW  dmem combinational read data
- `busy`  out  1  high when state ≠ IDLE

## Operation
- State machine: IDLE, OWN0, OWN1. Outputs decode from state only: `gnt0` = OWN0, `gnt1` = OWN1.
- Registers: state; `cnt`, width $clog2(MAX_BURST+1), counting the current owner's granted cycles; `last`, the last owner served.
- IDLE:
  - Only `reqX` high → OWNX.
  - Both high → tie-break (see Configuration).
  - Neither high → stay IDLE.
- OWNX with `reqX` high:
  - If the other requester is waiting and `cnt == MAX_BURST-1` → switch directly to the other owner, with `cnt` cleared.
  - Else stay and increment `cnt`, saturating at `MAX_BURST`.
- OWNX with `reqX` low:
  - Other requester waiting → switch to the other owner.
  - Else → IDLE.
  - `cnt` cleared in both cases.
- `last` is updated to X on every entry into OWNX.
- Memory mux (combinational):
  - Owner's `adr`/`wd` drive `DataAdr`/`WriteData`; IDLE drives zeros.
  - `MemWrite = weX & reqX & gntX` for the owner, so a dropped request in its final granted cycle issues no write.
- `rd0` and `rd1` both carry `ReadData` unconditionally. Requesters qualify it with their own `gnt`.

## Timing
- Grant latency: `req` sampled high at edge N → `gnt` high in the cycle after edge N (1 cycle). No combinational req→gnt path.
- Write commits at the `dmem` clock edge ending a cycle in which `gnt & req & we` holds.
- Handover has no idle gap: the new owner is granted in the cycle after the previous owner's last cycle.
- Max wait for a requester that holds `req` high: MAX_BURST+1 cycles.
- Reset: at the first edge with `reset` high, state → IDLE, `cnt` → 0, `last` → 1. Outputs after that edge: `gnt0`=`gnt1`=0, `busy`=0, `MemWrite`=0, `DataAdr`=0, `WriteData`=0.
- Reset mid-burst: grant is dropped at that edge and no further write issues. Requests still high after reset deasserts are re-arbitrated from IDLE.
- `MAX_BURST`=1 alternates owners every cycle under continuous contention.

## Configuration
- Macro `DMEM_ARB_RR_EN`:
  - Defined: round-robin tie-break in IDLE. Both requesting → grant the requester ≠ `last`. Requester 0 wins the first tie after reset, since `last` resets to 1.
  - Undefined: fixed priority; requester 0 always wins an IDLE tie. `last` is still maintained but ignored. Burst-limit preemption applies in both builds.

## Test plan
- Reset, then `req0`=1, `we0`=1, `adr0`=0x64, `wd0`=7 → `gnt0`=1 one cycle later. `MemWrite`=1, `DataAdr`=0x64, `WriteData`=7. A `dmem` read of 0x64 then returns 7.
- `req0` and `req1` rise in the same cycle, both held, `MAX_BURST`=4:
  - RR build: `gnt0` for 4 cycles, `gnt1` for 4, `gnt0` again, with no idle cycle between.
  - Fixed build: `gnt0` first, then the same alternation.
- `req1` burst of 2 writes (0x10←0xA, 0x14←0xB), then `req1` drops with `req0` pending → `gnt0` in the next cycle. Memory holds 0xA/0xB; no third write issued.
- `reset` asserted during cycle 2 of an OWN1 write burst → after the edge `gnt1`=0, `MemWrite`=0, `busy`=0. The address for cycle 3 is not written.
- Only `req1` high with `we1`=0, `adr1`=0x64 → `gnt1` after 1 cycle. `rd1` equals the stored word; `gnt0` stays 0 throughout.
- `MAX_BURST`=1 with both requests held → `gnt0`/`gnt1` alternate every cycle for 8 cycles.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the data memory port.
// The arbiter attaches to the slave modport; requesters and memory drive the master side.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // requester 0 (ARM core)
    logic          req0;
    logic          we0;
    logic [AW-1:0] adr0;
    logic [DW-1:0] wd0;
    logic          gnt0;
    logic [DW-1:0] rd0;

    // requester 1 (DMA / debug loader)
    logic          req1;
    logic          we1;
    logic [AW-1:0] adr1;
    logic [DW-1:0] wd1;
    logic          gnt1;
    logic [DW-1:0] rd1;

    // shared dmem port
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;

    logic          busy;

    modport master (
        output req0, we0, adr0, wd0,
        output req1, we1, adr1, wd1,
        output ReadData,
        input  gnt0, rd0, gnt1, rd1,
        input  MemWrite, DataAdr, WriteData, busy
    );

    modport slave (
        input  req0, we0, adr0, wd0,
        input  req1, we1, adr1, wd1,
        input  ReadData,
        output gnt0, rd0, gnt1, rd1,
        output MemWrite, DataAdr, WriteData, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single dmem port, registered (Moore) grants with burst limit.
// Define DMEM_ARB_RR_EN for a round-robin IDLE tie-break; otherwise requester 0 wins ties.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int            CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last, last_nxt;
    logic          tie_pick1;

    logic          mem_write;
    logic [AW-1:0] data_adr;
    logic [DW-1:0] write_data;

`ifdef DMEM_ARB_RR_EN
    assign tie_pick1 = ~last;
`else
    assign tie_pick1 = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.req0 && bus.req1) begin
                    state_nxt = tie_pick1 ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end
            end

            // >= rather than == so an owner whose count saturated while alone still yields
            OWN0: begin
                if (bus.req0) begin
                    if (bus.req1 && cnt >= BURST_LAST) begin
                        state_nxt = OWN1;
                        cnt_nxt   = '0;
                    end else if (cnt != BURST_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = bus.req1 ? OWN1 : IDLE;
                end
            end

            OWN1: begin
                if (bus.req1) begin
                    if (bus.req0 && cnt >= BURST_LAST) begin
                        state_nxt = OWN0;
                        cnt_nxt   = '0;
                    end else if (cnt != BURST_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = bus.req0 ? OWN0 : IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (state_nxt == OWN0 && state != OWN0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == OWN1 && state != OWN1) begin
            last_nxt = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Write is gated by the live request so a dropped request in its last granted cycle writes nothing
    always_comb begin
        mem_write  = 1'b0;
        data_adr   = '0;
        write_data = '0;
        unique case (state)
            OWN0: begin
                mem_write  = bus.we0 & bus.req0;
                data_adr   = bus.adr0;
                write_data = bus.wd0;
            end
            OWN1: begin
                mem_write  = bus.we1 & bus.req1;
                data_adr   = bus.adr1;
                write_data = bus.wd1;
            end
            default: ;
        endcase
    end

    assign bus.gnt0      = (state == OWN0);
    assign bus.gnt1      = (state == OWN1);
    assign bus.busy      = (state != IDLE);
    assign bus.MemWrite  = mem_write;
    assign bus.DataAdr   = data_adr;
    assign bus.WriteData = write_data;
    assign bus.rd0       = bus.ReadData;
    assign bus.rd1       = bus.ReadData;
endmodule
